if_id_ctrl: RTL and testbench

IF/ID pipeline register with front-end control for the 5-stage MIPS32 core. It consumes the fetch stage's `instruction`/`outpc` pair and holds the decode-stage copy. It detects load-use and branch-operand hazards and resolves `j`/`jal`/`beq`/`bne`/`jr` in decode. It drives back to the fetch stage the `stall`, `jump_cs` and `Next_pc` controls that steer the program counter.

---
 rtl/if_id_ctrl.sv | 159 +++++++++++++++
 tb/tb_if_id_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_ctrl.sv
// IF/ID pipeline register with decode-stage hazard detection and branch/jump resolution.
// Drives stall, bubble and redirect controls back to the fetch stage.
module if_id_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] outpc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dest,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        bubble,
    output logic        stall,
    output logic        jump_cs,
    output logic [31:0] Next_pc
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;

    logic [31:0] id_instruction_q, id_instruction_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] imm26;

    logic        is_jump;
    logic        is_beq;
    logic        is_bne;
    logic        is_jr;

    logic        load_use_haz;
    logic        branch_haz;
    logic        stall_int;
    logic        taken;
    logic        jump_int;
    logic [31:0] pc4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;

    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] hz);
        return (r != 5'd0) && (r == hz);
    endfunction

    always_comb begin
        op    = id_instruction_q[31:26];
        rs    = id_instruction_q[25:21];
        rt    = id_instruction_q[20:16];
        funct = id_instruction_q[5:0];
        imm16 = id_instruction_q[15:0];
        imm26 = id_instruction_q[25:0];

        is_jump = (op == OP_J) || (op == OP_JAL);
        is_beq  = (op == OP_BEQ);
        is_bne  = (op == OP_BNE);
        is_jr   = (op == OP_SPECIAL) && (funct == FN_JR);
    end

    // Hazards only count for a live decode slot; a flushed slot never stalls.
    always_comb begin
        load_use_haz = id_valid_q && ex_mem_read &&
                       (reg_match(rs, ex_dest) || reg_match(rt, ex_dest));

        branch_haz = 1'b0;
        if (id_valid_q && (is_beq || is_bne || is_jr)) begin
            if (ex_reg_write && reg_match(rs, ex_dest))
                branch_haz = 1'b1;
            if (mem_mem_read && reg_match(rs, mem_dest))
                branch_haz = 1'b1;
            if (!is_jr) begin
                if (ex_reg_write && reg_match(rt, ex_dest))
                    branch_haz = 1'b1;
                if (mem_mem_read && reg_match(rt, mem_dest))
                    branch_haz = 1'b1;
            end
        end

        stall_int = load_use_haz || branch_haz;
    end

    always_comb begin
        pc4           = id_pc_q + 32'd4;
        branch_target = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
        jump_target   = {pc4[31:28], imm26, 2'b00};

        taken  = 1'b0;
        target = 32'h0;
        if (is_jump) begin
            taken  = 1'b1;
            target = jump_target;
        end else if (is_beq) begin
            taken  = (rs_data == rt_data);
            target = branch_target;
        end else if (is_bne) begin
            taken  = (rs_data != rt_data);
            target = branch_target;
        end else if (is_jr) begin
            taken  = 1'b1;
            target = rs_data;
        end

        jump_int = id_valid_q && !stall_int && taken;
    end

    // Stall holds the slot; a redirect flushes the wrong-path fetch (no delay slot).
    always_comb begin
        id_instruction_d = instruction;
        id_pc_d          = outpc;
        id_valid_d       = 1'b1;
        if (stall_int) begin
            id_instruction_d = id_instruction_q;
            id_pc_d          = id_pc_q;
            id_valid_d       = id_valid_q;
        end else if (jump_int) begin
            id_instruction_d = 32'h0;
            id_pc_d          = outpc;
            id_valid_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_instruction_q <= 32'h0;
            id_pc_q          <= RESET_PC;
            id_valid_q       <= 1'b0;
        end else begin
            id_instruction_q <= id_instruction_d;
            id_pc_q          <= id_pc_d;
            id_valid_q       <= id_valid_d;
        end
    end

    assign id_instruction = id_instruction_q;
    assign id_pc          = id_pc_q;
    assign id_valid       = id_valid_q;
    assign stall          = stall_int;
    assign bubble         = stall_int || !id_valid_q;
    assign jump_cs        = jump_int;
    assign Next_pc        = jump_int ? target : 32'h0;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed bench for if_id_ctrl: per-cycle comparison against a behavioural model
// plus literal expectations at the key points of the directed sequence.
module tb_if_id_ctrl;

    localparam logic [31:0] RPC  = 32'hBFC0_0000;
    localparam logic [31:0] ADDI = 32'h2001_0001; // addi $1,$0,1
    localparam logic [31:0] ADD  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] BEQ  = 32'h1085_0003; // beq  $4,$5,+3
    localparam logic [31:0] BNE  = 32'h1485_FFFF; // bne  $4,$5,-1
    localparam logic [31:0] JMP  = 32'h0800_0040; // j    0x40
    localparam logic [31:0] JR   = 32'h03E0_0008; // jr   $31

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic [31:0] outpc = 32'h0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_dest = 5'd0;
    logic        mem_mem_read = 1'b0;
    logic [4:0]  mem_dest = 5'd0;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        bubble;
    logic        stall;
    logic        jump_cs;
    logic [31:0] Next_pc;

    int checks = 0;
    int failures = 0;

    if_id_ctrl #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .outpc(outpc),
        .rs_data(rs_data), .rt_data(rt_data), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_dest(ex_dest), .mem_mem_read(mem_mem_read),
        .mem_dest(mem_dest), .id_instruction(id_instruction), .id_pc(id_pc),
        .id_valid(id_valid), .bubble(bubble), .stall(stall), .jump_cs(jump_cs),
        .Next_pc(Next_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ins, m_pc;
    logic        m_valid;
    bit          m_known = 0;

    function automatic bit hz(input logic [4:0] r, input logic [4:0] d);
        return (r != 0) && (r == d);
    endfunction

    function automatic void model_eval(output bit e_stall, output bit e_jump, output logic [31:0] e_next);
        int unsigned op, rs, rt, fn;
        bit uses_rs, uses_rt, lu, bh, tk;
        logic [31:0] pc4, tgt;
        op = m_ins[31:26]; rs = m_ins[25:21]; rt = m_ins[20:16]; fn = m_ins[5:0];
        uses_rs = (op == 4) || (op == 5) || (op == 0 && fn == 8);
        uses_rt = (op == 4) || (op == 5);
        lu = m_valid && ex_mem_read && (hz(5'(rs), ex_dest) || hz(5'(rt), ex_dest));
        bh = m_valid && ((uses_rs && ((ex_reg_write && hz(5'(rs), ex_dest)) || (mem_mem_read && hz(5'(rs), mem_dest)))) ||
                         (uses_rt && ((ex_reg_write && hz(5'(rt), ex_dest)) || (mem_mem_read && hz(5'(rt), mem_dest)))));
        e_stall = lu || bh;
        pc4 = m_pc + 32'd4;
        tk = 0; tgt = 0;
        case (op)
            2, 3: begin tk = 1; tgt = (pc4 & 32'hF000_0000) | (32'(m_ins[25:0]) * 4); end
            4: begin tk = (rs_data == rt_data); tgt = pc4 + 32'($signed(m_ins[15:0])) * 4; end
            5: begin tk = (rs_data != rt_data); tgt = pc4 + 32'($signed(m_ins[15:0])) * 4; end
            0: if (fn == 8) begin tk = 1; tgt = rs_data; end
            default: ;
        endcase
        e_jump = m_valid && !e_stall && tk;
        e_next = e_jump ? tgt : 32'h0;
    endfunction

    always @(posedge clk) begin
        bit s, j;
        logic [31:0] n;
        model_eval(s, j, n);
        if (reset) begin
            m_known <= 1;
            m_ins <= 0; m_pc <= RPC; m_valid <= 0;
        end else if (m_known) begin
            if (s) begin
                m_ins <= m_ins; m_pc <= m_pc; m_valid <= m_valid;
            end else if (j) begin
                m_ins <= 0; m_pc <= outpc; m_valid <= 0;
            end else begin
                m_ins <= instruction; m_pc <= outpc; m_valid <= 1;
            end
        end
    end

    always @(negedge clk) begin
        bit s, j;
        logic [31:0] n;
        if (m_known) begin
            model_eval(s, j, n);
            chk("m_id_instruction", id_instruction, m_ins);
            chk("m_id_pc", id_pc, m_pc);
            chk("m_id_valid", 32'(id_valid), 32'(m_valid));
            chk("m_stall", 32'(stall), 32'(s));
            chk("m_bubble", 32'(bubble), 32'(s || !m_valid));
            chk("m_jump_cs", 32'(jump_cs), 32'(j));
            chk("m_Next_pc", Next_pc, n);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic exrw, input logic exmr, input logic [4:0] exd,
                         input logic mmr, input logic [4:0] md);
        @(posedge clk);
        #1;
        reset = rst; instruction = ins; outpc = pc; rs_data = rsd; rt_data = rtd;
        ex_reg_write = exrw; ex_mem_read = exmr; ex_dest = exd;
        mem_mem_read = mmr; mem_dest = md;
        @(negedge clk);
        $display("cycle t=%0t rst=%0b ins=%h pc=%h -> id_pc=%h v=%0b stall=%0b bub=%0b jmp=%0b npc=%h",
                 $time, rst, ins, pc, id_pc, id_valid, stall, bubble, jump_cs, Next_pc);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, ADDI, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_id_valid", 32'(id_valid), 0);
        chk("rst_id_pc", id_pc, RPC);
        chk("rst_id_instr", id_instruction, 0);
        chk("rst_bubble", 32'(bubble), 1);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_jump", 32'(jump_cs), 0);
        chk("rst_next", Next_pc, 0);
        drive(0, ADDI, 32'h4, 0, 0, 0, 0, 0, 0, 0);
        chk("stream_pc0", id_pc, 32'h0);
        chk("stream_valid", 32'(id_valid), 1);
        drive(0, ADD, 32'h8, 0, 0, 0, 0, 0, 0, 0);
        chk("stream_pc4", id_pc, 32'h4);
        chk("stream_nostall", 32'(stall), 0);
        // load-use on $1
        drive(0, ADDI, 32'hC, 0, 0, 0, 1, 5'd1, 0, 0);
        chk("lu_stall", 32'(stall), 1);
        chk("lu_bubble", 32'(bubble), 1);
        chk("lu_pc", id_pc, 32'h8);
        drive(0, ADDI, 32'hC, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_held_instr", id_instruction, ADD);
        chk("lu_held_pc", id_pc, 32'h8);
        chk("lu_release", 32'(stall), 0);
        // dest 0 never stalls
        drive(0, BEQ, 32'h100, 0, 0, 0, 1, 5'd0, 0, 0);
        chk("dest0_stall", 32'(stall), 0);
        chk("dest0_pc", id_pc, 32'hC);
        // beq taken
        drive(0, 0, 32'h104, 7, 7, 0, 0, 0, 0, 0);
        chk("beq_jump", 32'(jump_cs), 1);
        chk("beq_next", Next_pc, 32'h110);
        drive(0, 0, 32'h108, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_valid", 32'(id_valid), 0);
        chk("flush_pc", id_pc, 32'h104);
        chk("flush_jump", 32'(jump_cs), 0);
        chk("flush_bubble", 32'(bubble), 1);
        // beq not taken
        drive(0, BEQ, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h104, 7, 8, 0, 0, 0, 0, 0);
        chk("beq_nt_jump", 32'(jump_cs), 0);
        chk("beq_nt_next", Next_pc, 0);
        // bne backward to itself
        drive(0, BNE, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h204, 1, 2, 0, 0, 0, 0, 0);
        chk("bne_jump", 32'(jump_cs), 1);
        chk("bne_next", Next_pc, 32'h200);
        // j in upper region
        drive(0, JMP, 32'h1000_0000, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h1000_0004, 0, 0, 0, 0, 0, 0, 0);
        chk("j_next", Next_pc, 32'h1000_0100);
        chk("j_jump", 32'(jump_cs), 1);
        // jr with operand in EX, then a load in MEM
        drive(0, JR, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h304, 32'h999, 0, 1, 0, 5'd31, 0, 0);
        chk("jr_ex_stall", 32'(stall), 1);
        chk("jr_ex_nojump", 32'(jump_cs), 0);
        drive(0, 0, 32'h304, 32'h999, 0, 0, 0, 0, 1, 5'd31);
        chk("jr_mem_stall", 32'(stall), 1);
        drive(0, 0, 32'h304, 32'h400, 0, 0, 0, 0, 0, 0);
        chk("jr_jump", 32'(jump_cs), 1);
        chk("jr_next", Next_pc, 32'h400);
        chk("jr_pc", id_pc, 32'h300);
        // reset during stall
        drive(0, ADD, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h404, 0, 0, 0, 1, 5'd2, 0, 0);
        chk("pre_rst_stall", 32'(stall), 1);
        drive(1, 0, 32'h404, 0, 0, 0, 1, 5'd2, 0, 0);
        drive(0, JMP, 32'h500, 0, 0, 0, 0, 0, 0, 0);
        chk("rs_stall_valid", 32'(id_valid), 0);
        chk("rs_stall_pc", id_pc, RPC);
        chk("rs_stall_stall", 32'(stall), 0);
        chk("rs_stall_bubble", 32'(bubble), 1);
        // reset during redirect
        drive(0, 0, 32'h504, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_jump", 32'(jump_cs), 1);
        chk("pre_rst_next", Next_pc, 32'h100);
        drive(1, 0, 32'h504, 0, 0, 0, 0, 0, 0, 0);
        drive(0, ADDI, 32'h600, 0, 0, 0, 0, 0, 0, 0);
        chk("rs_jump_valid", 32'(id_valid), 0);
        chk("rs_jump_pc", id_pc, RPC);
        chk("rs_jump_jump", 32'(jump_cs), 0);
        chk("rs_jump_next", Next_pc, 0);
        drive(0, 0, 32'h604, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_pc", id_pc, 32'h600);
        chk("post_rst_valid", 32'(id_valid), 1);
        drive(0, 0, 32'h608, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 32'h60C, 0, 0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
